// File: rtl/pc_sequencer_pkg.sv
// Shared types for the fetch-stage PC sequencer: word type, FSM states and
// the pending-redirect record.
package pc_sequencer_pkg;

   typedef logic [31:0] vec32_t;

   typedef enum logic [1:0] {
      RUN,
      MEM_WAIT,
      HALTED
   } state_e;

   typedef struct packed {
      logic   valid;
      logic   from_ex;
      vec32_t target;
   } redirect_t;

   function automatic vec32_t word_align(vec32_t addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of fetch handshake, redirect requests and PC-control outputs
// between the pipeline (master) and the PC sequencer (slave).
interface pc_sequencer_if #(
   parameter int unsigned CNT_W = 32
);
   import pc_sequencer_pkg::*;

   logic             imem_req;
   logic             imem_ready;
   logic             load_use_hazard;
   logic             ex_branch_taken;
   vec32_t           ex_branch_target;
   logic             id_jump;
   vec32_t           id_jump_target;
   logic             halt_req;
   logic             pc_stall;
   logic             pc_jump_en;
   vec32_t           pc_jump_target;
   logic             flush_if;
   logic             flush_id;
   logic             halted;
   logic             mem_timeout;
   logic             align_error;
   logic [CNT_W-1:0] stall_cycles;

   modport slave (
      input  imem_ready, load_use_hazard, ex_branch_taken, ex_branch_target,
             id_jump, id_jump_target, halt_req,
      output imem_req, pc_stall, pc_jump_en, pc_jump_target, flush_if,
             flush_id, halted, mem_timeout, align_error, stall_cycles
   );

   modport master (
      output imem_ready, load_use_hazard, ex_branch_taken, ex_branch_target,
             id_jump, id_jump_target, halt_req,
      input  imem_req, pc_stall, pc_jump_en, pc_jump_target, flush_if,
             flush_id, halted, mem_timeout, align_error, stall_cycles
   );

endinterface

// File: rtl/pc_sequencer_stall_counter.sv
// Saturating up-counter with synchronous clear; used for stall cycles and
// the fetch timeout.
module stall_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clear_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;

   always_ff @(posedge clock) begin
      if (reset || clear_i) begin
         count_q <= '0;
      end else if (inc_i && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: merges stalls, arbitrates redirects (holding one
// across instruction-memory waits), drives flushes, halt and error flags.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 32
) (
   input  logic          clock,
   input  logic          reset,
   pc_sequencer_if.slave bus
);

   localparam int unsigned   TW     = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(MEM_TIMEOUT - 1);

   state_e           state_q, state_d;
   redirect_t        pend_q, pend_d, win;
   logic             mem_timeout_q, mem_timeout_d;
   logic             align_error_q, align_error_d;
   logic             is_halted, mem_stall, redirect, jump_en, pc_stall;
   logic             halt_go, tcnt_inc, tcnt_clr;
   logic [TW-1:0]    tcnt;
   logic [CNT_W-1:0] stall_cnt;

   always_comb begin
      is_halted = (state_q == HALTED);
      mem_stall = !is_halted && !bus.imem_ready;

      win = '0;
      if (bus.ex_branch_taken) begin
         win = '{valid: 1'b1, from_ex: 1'b1, target: bus.ex_branch_target};
      end else if (pend_q.valid) begin
         win = pend_q;
      end else if (bus.id_jump && !bus.load_use_hazard) begin
         win = '{valid: 1'b1, from_ex: 1'b0, target: bus.id_jump_target};
      end

      redirect = win.valid && !is_halted;
      jump_en  = redirect && !mem_stall;
      // A redirect that actually loads the PC always releases the stall,
      // including a held redirect landing while ID has a load-use hazard.
      pc_stall = is_halted || mem_stall || (bus.load_use_hazard && !jump_en);
      halt_go  = bus.halt_req && !win.valid && !pc_stall;

      pend_d = pend_q;
      if (redirect) begin
         pend_d = mem_stall ? win : '0;
      end

      align_error_d = align_error_q || (redirect && (win.target[1:0] != 2'b00));
      mem_timeout_d = mem_timeout_q;
      tcnt_inc      = (state_q == MEM_WAIT) && !bus.imem_ready;
      tcnt_clr      = (state_q == MEM_WAIT) && bus.imem_ready;

      state_d = state_q;
      unique case (state_q)
         RUN: begin
            if (mem_stall)    state_d = MEM_WAIT;
            else if (halt_go) state_d = HALTED;
         end
         MEM_WAIT: begin
            if (bus.imem_ready) begin
               state_d = halt_go ? HALTED : RUN;
            end else if (tcnt == T_LAST) begin
               state_d       = HALTED;
               mem_timeout_d = 1'b1;
            end
         end
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= RUN;
         pend_q        <= '0;
         mem_timeout_q <= 1'b0;
         align_error_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pend_q        <= pend_d;
         mem_timeout_q <= mem_timeout_d;
         align_error_q <= align_error_d;
      end
   end

   stall_counter #(.W(CNT_W)) u_stall_cnt (
      .clock   (clock),
      .reset   (reset),
      .clear_i (1'b0),
      .inc_i   (pc_stall),
      .count_o (stall_cnt)
   );

   stall_counter #(.W(TW)) u_timeout_cnt (
      .clock   (clock),
      .reset   (reset),
      .clear_i (tcnt_clr),
      .inc_i   (tcnt_inc),
      .count_o (tcnt)
   );

   assign bus.imem_req       = !is_halted;
   assign bus.pc_stall       = pc_stall;
   assign bus.pc_jump_en     = jump_en;
   assign bus.pc_jump_target = word_align(win.target);
   assign bus.flush_if       = redirect;
   assign bus.flush_id       = redirect && win.from_ex;
   assign bus.halted         = is_halted;
   assign bus.mem_timeout    = mem_timeout_q;
   assign bus.align_error    = align_error_q;
   assign bus.stall_cycles   = stall_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a short fetch timeout and an 8-bit
// stall counter so that timeout and saturation are reachable.
module tb_pc_sequencer;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clock = ~clock;

   pc_sequencer_if #(.CNT_W(8)) bus ();

   pc_sequencer #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus.imem_ready       = 1'b1;
      bus.load_use_hazard  = 1'b0;
      bus.ex_branch_taken  = 1'b0;
      bus.ex_branch_target = '0;
      bus.id_jump          = 1'b0;
      bus.id_jump_target   = '0;
      bus.halt_req         = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL rst_imem_req got %b exp 1", bus.imem_req); end
      checks++; if (bus.pc_stall !== 1'b0) begin errors++; $display("FAIL rst_pc_stall got %b exp 0", bus.pc_stall); end
      checks++; if (bus.pc_jump_en !== 1'b0) begin errors++; $display("FAIL rst_jump_en got %b exp 0", bus.pc_jump_en); end
      checks++; if ({bus.halted, bus.mem_timeout, bus.align_error} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {bus.halted, bus.mem_timeout, bus.align_error}); end
      repeat (10) tick();
      checks++; if (bus.stall_cycles !== 8'd0) begin errors++; $display("FAIL idle_stall_cycles got %0d exp 0", bus.stall_cycles); end
      checks++; if (bus.pc_stall !== 1'b0 || bus.pc_jump_en !== 1'b0) begin errors++; $display("FAIL idle_outputs got stall=%b jump=%b exp 0 0", bus.pc_stall, bus.pc_jump_en); end
   endtask

   task automatic test_id_jump();
      bus.id_jump = 1'b1; bus.id_jump_target = 32'h0040_0020;
      #1;
      checks++; if (bus.pc_jump_en !== 1'b1) begin errors++; $display("FAIL jmp_en got %b exp 1", bus.pc_jump_en); end
      checks++; if (bus.pc_jump_target !== 32'h0040_0020) begin errors++; $display("FAIL jmp_target got %h exp 00400020", bus.pc_jump_target); end
      checks++; if ({bus.flush_if, bus.flush_id} !== 2'b10) begin errors++; $display("FAIL jmp_flush got %b exp 10", {bus.flush_if, bus.flush_id}); end
      tick();
      // a jump behind a load-use hazard is held off, PC stalls
      bus.load_use_hazard = 1'b1;
      #1;
      checks++; if ({bus.pc_jump_en, bus.pc_stall, bus.flush_if} !== 3'b010) begin errors++; $display("FAIL jmp_luh got %b exp 010", {bus.pc_jump_en, bus.pc_stall, bus.flush_if}); end
      tick();
      idle_inputs();
   endtask

   task automatic test_priority();
      bus.ex_branch_taken = 1'b1; bus.ex_branch_target = 32'h100;
      bus.id_jump = 1'b1; bus.id_jump_target = 32'h200;
      bus.load_use_hazard = 1'b1;
      #1;
      checks++; if (bus.pc_jump_target !== 32'h100) begin errors++; $display("FAIL prio_target got %h exp 00000100", bus.pc_jump_target); end
      checks++; if ({bus.pc_jump_en, bus.pc_stall} !== 2'b10) begin errors++; $display("FAIL prio_en_stall got %b exp 10", {bus.pc_jump_en, bus.pc_stall}); end
      checks++; if ({bus.flush_if, bus.flush_id} !== 2'b11) begin errors++; $display("FAIL prio_flush got %b exp 11", {bus.flush_if, bus.flush_id}); end
      tick();
      idle_inputs();
   endtask

   task automatic test_mem_wait();
      do_reset();
      bus.imem_ready = 1'b0; bus.ex_branch_taken = 1'b1; bus.ex_branch_target = 32'h300;
      #1;
      checks++; if ({bus.pc_jump_en, bus.pc_stall} !== 2'b01) begin errors++; $display("FAIL mw_c1 got %b exp 01", {bus.pc_jump_en, bus.pc_stall}); end
      checks++; if ({bus.flush_if, bus.flush_id} !== 2'b11) begin errors++; $display("FAIL mw_c1_flush got %b exp 11", {bus.flush_if, bus.flush_id}); end
      tick();
      bus.ex_branch_taken = 1'b0; bus.ex_branch_target = '0;
      for (int c = 2; c <= 3; c++) begin
         #1;
         checks++; if ({bus.pc_jump_en, bus.pc_stall} !== 2'b01) begin errors++; $display("FAIL mw_c%0d got %b exp 01", c, {bus.pc_jump_en, bus.pc_stall}); end
         tick();
      end
      bus.imem_ready = 1'b1;
      #1;
      checks++; if ({bus.pc_jump_en, bus.pc_stall, bus.flush_id} !== 3'b101) begin errors++; $display("FAIL mw_c4 got %b exp 101", {bus.pc_jump_en, bus.pc_stall, bus.flush_id}); end
      checks++; if (bus.pc_jump_target !== 32'h300) begin errors++; $display("FAIL mw_c4_target got %h exp 00000300", bus.pc_jump_target); end
      checks++; if (bus.stall_cycles !== 8'd3) begin errors++; $display("FAIL mw_stall_cycles got %0d exp 3", bus.stall_cycles); end
      tick();
      checks++; if (bus.pc_jump_en !== 1'b0) begin errors++; $display("FAIL mw_pend_cleared got %b exp 0", bus.pc_jump_en); end
   endtask

   task automatic test_pending_overwrite();
      do_reset();
      bus.imem_ready = 1'b0; bus.id_jump = 1'b1; bus.id_jump_target = 32'h400;
      #1;
      checks++; if ({bus.pc_jump_en, bus.flush_if, bus.flush_id} !== 3'b010) begin errors++; $display("FAIL ow_capture got %b exp 010", {bus.pc_jump_en, bus.flush_if, bus.flush_id}); end
      tick();
      bus.id_jump_target = 32'h600;
      #1;
      checks++; if (bus.pc_jump_target !== 32'h400) begin errors++; $display("FAIL ow_id_keeps got %h exp 00000400", bus.pc_jump_target); end
      tick();
      bus.id_jump = 1'b0; bus.ex_branch_taken = 1'b1; bus.ex_branch_target = 32'h500;
      tick();
      idle_inputs();
      #1;
      checks++; if ({bus.pc_jump_en, bus.flush_id} !== 2'b11) begin errors++; $display("FAIL ow_apply got %b exp 11", {bus.pc_jump_en, bus.flush_id}); end
      checks++; if (bus.pc_jump_target !== 32'h500) begin errors++; $display("FAIL ow_ex_wins got %h exp 00000500", bus.pc_jump_target); end
      tick();
   endtask

   task automatic test_reset_pending();
      do_reset();
      bus.imem_ready = 1'b0; bus.id_jump = 1'b1; bus.id_jump_target = 32'h700;
      tick();
      do_reset();
      checks++; if ({bus.pc_jump_en, bus.flush_if} !== 2'b00) begin errors++; $display("FAIL rstpend got %b exp 00", {bus.pc_jump_en, bus.flush_if}); end
   endtask

   task automatic test_timeout();
      do_reset();
      bus.imem_ready = 1'b0;
      repeat (4) tick();
      checks++; if ({bus.halted, bus.mem_timeout} !== 2'b00) begin errors++; $display("FAIL to_early got %b exp 00", {bus.halted, bus.mem_timeout}); end
      tick();
      checks++; if ({bus.halted, bus.mem_timeout} !== 2'b11) begin errors++; $display("FAIL to_hit got %b exp 11", {bus.halted, bus.mem_timeout}); end
      checks++; if ({bus.imem_req, bus.pc_stall} !== 2'b01) begin errors++; $display("FAIL to_req_stall got %b exp 01", {bus.imem_req, bus.pc_stall}); end
      checks++; if (bus.stall_cycles !== 8'd5) begin errors++; $display("FAIL to_stall_cycles got %0d exp 5", bus.stall_cycles); end
      bus.imem_ready = 1'b1; bus.id_jump = 1'b1; bus.id_jump_target = 32'h800;
      #1;
      checks++; if ({bus.pc_jump_en, bus.flush_if, bus.flush_id, bus.pc_stall} !== 4'b0001) begin errors++; $display("FAIL halted_outputs got %b exp 0001", {bus.pc_jump_en, bus.flush_if, bus.flush_id, bus.pc_stall}); end
      repeat (300) tick();
      checks++; if (bus.stall_cycles !== 8'hFF) begin errors++; $display("FAIL stall_saturate got %h exp ff", bus.stall_cycles); end
      checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_sticky got %b exp 1", bus.halted); end
      do_reset();
      checks++; if ({bus.halted, bus.mem_timeout, bus.imem_req, bus.pc_stall} !== 4'b0010) begin errors++; $display("FAIL to_reset got %b exp 0010", {bus.halted, bus.mem_timeout, bus.imem_req, bus.pc_stall}); end
      checks++; if (bus.stall_cycles !== 8'd0) begin errors++; $display("FAIL to_reset_cnt got %0d exp 0", bus.stall_cycles); end
   endtask

   task automatic test_align_halt();
      do_reset();
      bus.id_jump = 1'b1; bus.id_jump_target = 32'h0000_0106;
      #1;
      checks++; if (bus.pc_jump_target !== 32'h0000_0104) begin errors++; $display("FAIL al_target got %h exp 00000104", bus.pc_jump_target); end
      tick();
      bus.id_jump = 1'b0; bus.halt_req = 1'b1;
      #1;
      checks++; if ({bus.align_error, bus.halted} !== 2'b10) begin errors++; $display("FAIL al_flag got %b exp 10", {bus.align_error, bus.halted}); end
      tick();
      bus.halt_req = 1'b0;
      checks++; if ({bus.halted, bus.imem_req, bus.pc_stall} !== 3'b101) begin errors++; $display("FAIL halt_enter got %b exp 101", {bus.halted, bus.imem_req, bus.pc_stall}); end
      repeat (3) tick();
      checks++; if (bus.align_error !== 1'b1) begin errors++; $display("FAIL al_sticky got %b exp 1", bus.align_error); end
   endtask

   task automatic test_halt_blocked();
      do_reset();
      bus.halt_req = 1'b1; bus.imem_ready = 1'b0;
      tick();
      checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_memstall got %b exp 0", bus.halted); end
      bus.imem_ready = 1'b1; bus.ex_branch_taken = 1'b1; bus.ex_branch_target = 32'h900;
      tick();
      checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_wrongpath got %b exp 0", bus.halted); end
      bus.ex_branch_taken = 1'b0; bus.load_use_hazard = 1'b1;
      tick();
      checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_luh got %b exp 0", bus.halted); end
      bus.load_use_hazard = 1'b0;
      tick();
      checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_release got %b exp 1", bus.halted); end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_id_jump();
      test_priority();
      test_mem_wait();
      test_pending_overwrite();
      test_reset_pending();
      test_timeout();
      test_align_halt();
      test_halt_blocked();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controls the fetch-stage program counter register and sequences it.
- Combines hazard stalls, instruction-memory wait and halt into the single PC stall signal.
- Arbitrates branch/jump redirect requests into one jump-enable/target pair, and holds a redirect that arrives while fetch is blocked.
- Drives pipeline flushes and keeps a stall-cycle performance counter and sticky error flags.

Parameters:
- MEM_TIMEOUT, 255: consecutive not-ready cycles before a fetch is declared hung.
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- imem_req  output  1  fetch request to instruction memory
- imem_ready  input  1  instruction memory accepts/returns this cycle
- load_use_hazard  input  1  ID instruction depends on a load in EX
- ex_branch_taken  input  1  branch resolved taken in EX
- ex_branch_target  input  32  branch target
- id_jump  input  1  unconditional jump decoded in ID
- id_jump_target  input  32  jump target
- halt_req  input  1  halt/syscall decoded in ID
- pc_stall  output  1  hold PC register
- pc_jump_en  output  1  load PC with pc_jump_target
- pc_jump_target  output  32  redirect target, bits [1:0] forced to 0
- flush_if  output  1  squash the IF/ID register
- flush_id  output  1  squash the ID/EX register
- halted  output  1  core halted, PC frozen
- mem_timeout  output  1  sticky: fetch hung
- align_error  output  1  sticky: a redirect target had nonzero [1:0]
- stall_cycles  output  CNT_W  saturating count of cycles with pc_stall=1

Behaviour:
- FSM states: RUN, MEM_WAIT, HALTED. Reset enters RUN and clears:
  - the pending-redirect register (valid=0, target=0);
  - the timeout counter, stall_cycles, mem_timeout, align_error and halted.
- Reset mid-operation discards any pending redirect.
- imem_req = 1 in RUN and MEM_WAIT, 0 in HALTED.
- RUN: imem_req & !imem_ready moves to MEM_WAIT.
- MEM_WAIT: imem_ready returns to RUN and clears the timeout counter.
- Timeout: each MEM_WAIT cycle with !imem_ready increments the timeout counter. When it reaches MEM_TIMEOUT, set mem_timeout and go to HALTED.
- mem_stall = imem_req & !imem_ready. All outputs are combinational from state and inputs, so a redirect takes effect on the next clock edge (latency 1).
- Redirect priority:
  1. ex_branch_taken (oldest instruction).
  2. Pending redirect.
  3. id_jump.
- id_jump is ignored while load_use_hazard=1; the stalled jump is re-presented.
- Effective redirect when mem_stall=0 and not HALTED:
  - pc_jump_en=1, pc_stall=0, pending cleared.
  - flush_if=1.
  - flush_id=1 only when the winner is ex_branch_taken, or a pending entry captured from EX.
- ex_branch_taken overrides load_use_hazard: the PC is not stalled and both flushes fire.
- Redirect while mem_stall=1:
  - Capture into pending (target, from_ex bit); pc_jump_en=0, pc_stall=1.
  - An ex branch overwrites a pending id_jump. An id_jump never overwrites a pending entry.
  - Flushes still assert in the capture cycle.
- Pending entry applies on the first cycle with mem_stall=0.
- pc_stall = mem_stall | (load_use_hazard & !ex_branch_taken) | HALTED.
- halt_req with no redirect and no stall: go to HALTED at the next edge.
- halt_req during stall: it is re-presented; the pipeline does not flush it.
- halt_req in the same cycle as ex_branch_taken: ignored (the halt is on the wrong path).
- HALTED: pc_stall=1, pc_jump_en=0, flushes 0, halted=1. Exit only by reset.
- align_error sets when a winning target has bits [1:0] != 0; the target is still used with [1:0]=0.
- stall_cycles increments each cycle pc_stall=1 and saturates at all-ones.

Decomposition:
- Shared package:
  - Vec32 typedef.
  - FSM state enum.
  - redirect_t struct: valid, from_ex, target.
- Sub-module: stall_counter (parameterised saturating counter), reused for stall_cycles and the timeout counter with a clear input.

Test Plan:
- Reset, then imem_ready=1 constantly, no requests: imem_req=1, pc_stall=0, pc_jump_en=0, stall_cycles=0 after 10 cycles.
- id_jump=1 with target 0x0040_0020: same cycle pc_jump_en=1, target=0x0040_0020, flush_if=1, flush_id=0.
- Same cycle: ex_branch_taken to 0x100, id_jump to 0x200, load_use_hazard=1: target=0x100, pc_stall=0, both flushes=1.
- imem_ready=0 for 3 cycles, ex_branch to 0x300 in cycle 1: pc_jump_en=0 for cycles 1-3; cycle 4 (ready=1) pc_jump_en=1, target=0x300; stall_cycles=3.
- MEM_TIMEOUT=4, imem_ready stuck 0: mem_timeout=1 and halted=1 after 4 MEM_WAIT cycles. Then imem_req=0, pc_stall=1 until reset; reset clears all.
- id_jump target 0x0000_0106: align_error=1 (sticky), pc_jump_target=0x0000_0104. halt_req next cycle: halted=1 at the following edge.
